// File: rtl/reg_rename_file_if.sv
// rtl/reg_rename_file_if.sv - decode/ROB-side bus of the register rename file
//
// Purpose: groups every non-clock, non-reset signal of reg_rename_file.
// Modports:
//   master - decode/ROB side: drives rdy_in, source indices, allocation and commit;
//            receives rsN_val/rsN_busy/rsN_tag.
//   slave  - register rename file: the mirror image of master.
interface reg_rename_file_if #(
   parameter int ROB_TAG_W = 4,
   parameter int XLEN      = 32
);
   logic                 rdy_in;
   logic [4:0]           dec_rs1_idx;
   logic [4:0]           dec_rs2_idx;
   logic [XLEN-1:0]      rs1_val;
   logic                 rs1_busy;
   logic [ROB_TAG_W-1:0] rs1_tag;
   logic [XLEN-1:0]      rs2_val;
   logic                 rs2_busy;
   logic [ROB_TAG_W-1:0] rs2_tag;
   logic                 dec_rd_valid;
   logic [4:0]           dec_rd_idx;
   logic [ROB_TAG_W-1:0] dec_rd_tag;
   logic                 cmt_valid;
   logic [4:0]           cmt_rd_idx;
   logic [ROB_TAG_W-1:0] cmt_tag;
   logic [XLEN-1:0]      cmt_val;
   logic                 flush;

   modport master (
      output rdy_in, dec_rs1_idx, dec_rs2_idx,
      output dec_rd_valid, dec_rd_idx, dec_rd_tag,
      output cmt_valid, cmt_rd_idx, cmt_tag, cmt_val, flush,
      input  rs1_val, rs1_busy, rs1_tag, rs2_val, rs2_busy, rs2_tag
   );

   modport slave (
      input  rdy_in, dec_rs1_idx, dec_rs2_idx,
      input  dec_rd_valid, dec_rd_idx, dec_rd_tag,
      input  cmt_valid, cmt_rd_idx, cmt_tag, cmt_val, flush,
      output rs1_val, rs1_busy, rs1_tag, rs2_val, rs2_busy, rs2_tag
   );
endinterface

// File: rtl/reg_rename_file.sv
// rtl/reg_rename_file.sv - architectural register file plus register status (rename) table
//
// Purpose: holds committed register values and, per register, whether an in-flight
// ROB entry will produce it (busy) and which one (tag). Decode allocates rd->tag,
// the ROB commits values, flush drops all renames. Two combinational read ports.
// Ports:
//   clk_in  - clock, rising edge
//   rst_in  - asynchronous reset, active low
//   rf      - reg_rename_file_if.slave: rdy_in, rs1/rs2 lookup, allocation, commit, flush
// Optional feature: define REGFILE_COMMIT_BYPASS_EN to forward a same-cycle commit
// whose tag matches the live mapping straight to the read ports.
module reg_rename_file #(
   parameter int ROB_TAG_W = 4,
   parameter int XLEN      = 32,
   parameter int NREG      = 32
) (
   input logic               clk_in,
   input logic               rst_in,
   reg_rename_file_if.slave  rf
);

   logic [XLEN-1:0]      val_q [NREG];
   logic [XLEN-1:0]      val_d [NREG];
   logic [ROB_TAG_W-1:0] tag_q [NREG];
   logic [ROB_TAG_W-1:0] tag_d [NREG];
   logic [NREG-1:0]      busy_q;
   logic [NREG-1:0]      busy_d;

   logic alloc_hit;
   logic cmt_hit;

   // flush suppresses allocation; x0 is never written or renamed
   assign alloc_hit = rf.dec_rd_valid && (rf.dec_rd_idx != 5'd0) && !rf.flush;
   assign cmt_hit   = rf.cmt_valid && (rf.cmt_rd_idx != 5'd0);

   always_comb begin
      val_d  = val_q;
      tag_d  = tag_q;
      busy_d = busy_q;
      if (cmt_hit) begin
         val_d[rf.cmt_rd_idx] = rf.cmt_val;
         // only the producer currently mapped may retire the rename; a same-cycle
         // allocation of that register keeps it busy under the new tag
         if (busy_q[rf.cmt_rd_idx] && (tag_q[rf.cmt_rd_idx] == rf.cmt_tag) &&
             !(alloc_hit && (rf.dec_rd_idx == rf.cmt_rd_idx)))
            busy_d[rf.cmt_rd_idx] = 1'b0;
      end
      if (alloc_hit) begin
         busy_d[rf.dec_rd_idx] = 1'b1;
         tag_d[rf.dec_rd_idx]  = rf.dec_rd_tag;
      end
      if (rf.flush)
         busy_d = '0;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < NREG; i++) begin
            val_q[i] <= '0;
            tag_q[i] <= '0;
         end
         busy_q <= '0;
      end else if (rf.rdy_in) begin
         val_q  <= val_d;
         tag_q  <= tag_d;
         busy_q <= busy_d;
      end
   end

   // read ports see stored state, so a same-cycle allocation shows the old mapping
   always_comb begin
      rf.rs1_val  = '0;
      rf.rs1_busy = 1'b0;
      rf.rs1_tag  = '0;
      if (rf.dec_rs1_idx != 5'd0) begin
         rf.rs1_val  = val_q[rf.dec_rs1_idx];
         rf.rs1_busy = busy_q[rf.dec_rs1_idx];
         rf.rs1_tag  = tag_q[rf.dec_rs1_idx];
`ifdef REGFILE_COMMIT_BYPASS_EN
         if (rf.cmt_valid && (rf.cmt_rd_idx == rf.dec_rs1_idx) &&
             busy_q[rf.dec_rs1_idx] && (tag_q[rf.dec_rs1_idx] == rf.cmt_tag)) begin
            rf.rs1_val  = rf.cmt_val;
            rf.rs1_busy = 1'b0;
         end
`else
`endif
      end
   end

   always_comb begin
      rf.rs2_val  = '0;
      rf.rs2_busy = 1'b0;
      rf.rs2_tag  = '0;
      if (rf.dec_rs2_idx != 5'd0) begin
         rf.rs2_val  = val_q[rf.dec_rs2_idx];
         rf.rs2_busy = busy_q[rf.dec_rs2_idx];
         rf.rs2_tag  = tag_q[rf.dec_rs2_idx];
`ifdef REGFILE_COMMIT_BYPASS_EN
         if (rf.cmt_valid && (rf.cmt_rd_idx == rf.dec_rs2_idx) &&
             busy_q[rf.dec_rs2_idx] && (tag_q[rf.dec_rs2_idx] == rf.cmt_tag)) begin
            rf.rs2_val  = rf.cmt_val;
            rf.rs2_busy = 1'b0;
         end
`else
`endif
      end
   end

endmodule

// File: tb/tb_reg_rename_file.sv
// tb/tb_reg_rename_file.sv - self-checking bench for reg_rename_file
module tb_reg_rename_file;

   logic clk_in;
   logic rst_in;
   int   n_tests;
   int   n_fail;
   bit   check_en;

   reg_rename_file_if #(.ROB_TAG_W(4), .XLEN(32)) rf_if ();

   reg_rename_file #(.ROB_TAG_W(4), .XLEN(32), .NREG(32)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .rf     (rf_if)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // reference model: one entry per architectural register
   logic [31:0] m_val  [32];
   logic [3:0]  m_tag  [32];
   bit          m_busy [32];

   always @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < 32; i++) begin
            m_val[i] = 0; m_tag[i] = 0; m_busy[i] = 0;
         end
      end else if (rf_if.rdy_in) begin
         int  c, a;
         bit  retire, alloc;
         c = rf_if.cmt_rd_idx;
         a = rf_if.dec_rd_idx;
         retire = rf_if.cmt_valid && c != 0 && m_busy[c] && m_tag[c] == rf_if.cmt_tag;
         alloc  = rf_if.dec_rd_valid && a != 0 && !rf_if.flush;
         if (rf_if.cmt_valid && c != 0) m_val[c] = rf_if.cmt_val;
         if (rf_if.flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
         end else begin
            if (retire) m_busy[c] = 0;
            if (alloc) begin
               m_busy[a] = 1;
               m_tag[a]  = rf_if.dec_rd_tag;
            end
         end
      end
   end

   task automatic exp_read(input int idx, output logic [31:0] v, output bit b, output logic [3:0] t);
      v = 0; b = 0; t = 0;
      if (idx != 0) begin
         v = m_val[idx]; b = m_busy[idx]; t = m_tag[idx];
`ifdef REGFILE_COMMIT_BYPASS_EN
         if (rf_if.cmt_valid && rf_if.cmt_rd_idx == idx && m_busy[idx] && m_tag[idx] == rf_if.cmt_tag) begin
            v = rf_if.cmt_val; b = 0;
         end
`endif
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_in) begin
      if (check_en) begin
         logic [31:0] v;
         bit          b;
         logic [3:0]  t;
         exp_read(rf_if.dec_rs1_idx, v, b, t);
         chk("cmp_rs1_val", rf_if.rs1_val, v);
         chk("cmp_rs1_busy", {31'd0, rf_if.rs1_busy}, {31'd0, b});
         if (b) chk("cmp_rs1_tag", {28'd0, rf_if.rs1_tag}, {28'd0, t});
         exp_read(rf_if.dec_rs2_idx, v, b, t);
         chk("cmp_rs2_val", rf_if.rs2_val, v);
         chk("cmp_rs2_busy", {31'd0, rf_if.rs2_busy}, {31'd0, b});
         if (b) chk("cmp_rs2_tag", {28'd0, rf_if.rs2_tag}, {28'd0, t});
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
      rf_if.dec_rd_valid = 0;
      rf_if.cmt_valid    = 0;
      rf_if.flush        = 0;
   endtask

   task automatic alloc(input logic [4:0] idx, input logic [3:0] tag);
      rf_if.dec_rd_valid = 1; rf_if.dec_rd_idx = idx; rf_if.dec_rd_tag = tag;
   endtask

   task automatic commit(input logic [4:0] idx, input logic [3:0] tag, input logic [31:0] v);
      rf_if.cmt_valid = 1; rf_if.cmt_rd_idx = idx; rf_if.cmt_tag = tag; rf_if.cmt_val = v;
   endtask

   task automatic lit1(input string name, input logic [31:0] v, input bit b, input logic [3:0] t, input bit ct);
      chk({name, "_rs1_val"}, rf_if.rs1_val, v);
      chk({name, "_rs1_busy"}, {31'd0, rf_if.rs1_busy}, {31'd0, b});
      if (ct) chk({name, "_rs1_tag"}, {28'd0, rf_if.rs1_tag}, {28'd0, t});
   endtask

   task automatic lit2(input string name, input logic [31:0] v, input bit b, input logic [3:0] t, input bit ct);
      chk({name, "_rs2_val"}, rf_if.rs2_val, v);
      chk({name, "_rs2_busy"}, {31'd0, rf_if.rs2_busy}, {31'd0, b});
      if (ct) chk({name, "_rs2_tag"}, {28'd0, rf_if.rs2_tag}, {28'd0, t});
   endtask

   initial begin
      n_tests = 0; n_fail = 0; check_en = 0;
      rst_in = 0;
      rf_if.rdy_in = 1;
      rf_if.dec_rs1_idx = 5; rf_if.dec_rs2_idx = 0;
      rf_if.dec_rd_valid = 0; rf_if.dec_rd_idx = 0; rf_if.dec_rd_tag = 0;
      rf_if.cmt_valid = 0; rf_if.cmt_rd_idx = 0; rf_if.cmt_tag = 0; rf_if.cmt_val = 0;
      rf_if.flush = 0;
      tick(); tick();
      check_en = 1;
      #1 lit1("reset_x5", 32'h0, 0, 4'd0, 1);
      rst_in = 1;
      tick();

      // allocate then commit x5
      alloc(5, 3); tick();
      rf_if.dec_rs1_idx = 5;
      #1 lit1("alloc_x5", 32'h0, 1, 4'd3, 1);
      commit(5, 3, 32'hDEADBEEF);
      #1;
`ifdef REGFILE_COMMIT_BYPASS_EN
      lit1("bypass_x5", 32'hDEADBEEF, 0, 4'd0, 0);
`else
      lit1("nobypass_x5", 32'h0, 1, 4'd3, 1);
`endif
      tick();
      #1 lit1("commit_x5", 32'hDEADBEEF, 0, 4'd0, 0);

      // stale commit after a second rename
      alloc(7, 2); tick();
      alloc(7, 9); tick();
      commit(7, 2, 32'h11); tick();
      rf_if.dec_rs1_idx = 7;
      #1 lit1("stale_x7", 32'h11, 1, 4'd9, 1);

      // same-cycle allocate and commit of x4
      alloc(4, 1); tick();
      alloc(4, 6); commit(4, 1, 32'h22);
      rf_if.dec_rs2_idx = 4;
      #1;
`ifdef REGFILE_COMMIT_BYPASS_EN
      lit2("samecyc_x4", 32'h22, 0, 4'd0, 0);
`else
      lit2("samecyc_x4", 32'h0, 1, 4'd1, 1);
`endif
      tick();
      #1 lit2("after_x4", 32'h22, 1, 4'd6, 1);

      // flush with commit and allocation
      alloc(3, 5); tick();
      alloc(8, 7); tick();
      alloc(9, 8); tick();
      rf_if.flush = 1; commit(8, 7, 32'h55); alloc(10, 4); tick();
      rf_if.dec_rs1_idx = 8; rf_if.dec_rs2_idx = 10;
      #1 lit1("flush_x8", 32'h55, 0, 4'd0, 0);
      lit2("flush_x10", 32'h0, 0, 4'd0, 0);
      rf_if.dec_rs1_idx = 3; rf_if.dec_rs2_idx = 9;
      #1 lit1("flush_x3", 32'h0, 0, 4'd0, 0);
      lit2("flush_x9", 32'h0, 0, 4'd0, 0);

      // x0 is hardwired
      alloc(0, 5); commit(0, 5, 32'h99);
      rf_if.dec_rs1_idx = 0;
      #1 lit1("x0_same", 32'h0, 0, 4'd0, 1);
      tick();
      #1 lit1("x0_after", 32'h0, 0, 4'd0, 1);

      // bypass case for x5
      alloc(5, 3); tick();
      commit(5, 3, 32'h77);
      rf_if.dec_rs1_idx = 5;
      #1;
`ifdef REGFILE_COMMIT_BYPASS_EN
      lit1("bypass2_x5", 32'h77, 0, 4'd0, 0);
`else
      lit1("bypass2_x5", 32'hDEADBEEF, 1, 4'd3, 1);
`endif
      tick();
      #1 lit1("commit2_x5", 32'h77, 0, 4'd0, 0);

      // tag mismatch never bypasses
      alloc(6, 2); tick();
      commit(6, 5, 32'h33);
      rf_if.dec_rs2_idx = 6;
      #1 lit2("mismatch_x6", 32'h0, 1, 4'd2, 1);
      tick();
      #1 lit2("mismatch_after_x6", 32'h33, 1, 4'd2, 1);

      // rdy_in low holds all state
      rf_if.rdy_in = 0;
      alloc(11, 1); commit(6, 2, 32'h44); tick();
      rf_if.dec_rs1_idx = 11; rf_if.dec_rs2_idx = 6;
      #1 lit1("hold_x11", 32'h0, 0, 4'd0, 0);
      lit2("hold_x6", 32'h33, 1, 4'd2, 1);
      rf_if.rdy_in = 1;
      tick();

      // overlapping allocate/commit stream for the compare process
      for (int i = 1; i <= 10; i++) begin
         alloc(5'(i + 10), 4'(i));
         if (i > 1) commit(5'(i + 9), 4'(i - 1), 32'(i * 32'h101));
         rf_if.dec_rs1_idx = 5'(i + 10);
         rf_if.dec_rs2_idx = 5'(i + 9);
         tick();
      end

      // asynchronous reset between edges
      alloc(12, 4); tick();
      rf_if.dec_rs1_idx = 12; rf_if.dec_rs2_idx = 5;
      #2 rst_in = 0;
      #1 lit1("areset_x12", 32'h0, 0, 4'd0, 1);
      lit2("areset_x5", 32'h0, 0, 4'd0, 1);
      tick();
      #1 rst_in = 1;
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_rename_file.md
Name: reg_rename_file

Overview:
- Architectural register file plus register status (rename) table for the Tomasulo core.
- Sits directly downstream of the reorder buffer.
  - Consumes ROB commit writes: rd index, ROB tag, value.
  - Records decode's rd-to-ROB-tag allocations.
- Serves combinational rs1/rs2 lookups to decode/issue: either a committed value, or busy + the ROB tag to wait on.

Parameters:
- ROB_TAG_W, 4, width of ROB entry index (16-entry ROB).
- XLEN, 32, register data width.
- NREG, 32, number of architectural registers (index width fixed at 5).

Ports:
- clk_in  input  1  system clock, rising edge.
- rst_in  input  1  asynchronous reset, active-low.
- rdy_in  input  1  global ready; low = hold all state.
- dec_rs1_idx  input  5  source register 1 index.
- dec_rs2_idx  input  5  source register 2 index.
- rs1_val  output  XLEN  committed value of rs1.
- rs1_busy  output  1  rs1 awaiting an in-flight ROB entry.
- rs1_tag  output  ROB_TAG_W  ROB tag producing rs1 (valid when rs1_busy).
- rs2_val  output  XLEN  as rs1.
- rs2_busy  output  1  as rs1.
- rs2_tag  output  ROB_TAG_W  as rs1.
- dec_rd_valid  input  1  decode allocates a destination this cycle.
- dec_rd_idx  input  5  destination register index.
- dec_rd_tag  input  ROB_TAG_W  ROB entry assigned to that destination.
- cmt_valid  input  1  ROB commits an instruction with a register result.
- cmt_rd_idx  input  5  committed destination index.
- cmt_tag  input  ROB_TAG_W  ROB entry being committed.
- cmt_val  input  XLEN  committed result.
- flush  input  1  mispredict/exception recovery; discard all renames.

Behaviour:
- State per register: val[XLEN], busy[1], tag[ROB_TAG_W].
- Reset (rst_in low, asynchronous, any time incl. mid-operation): all val=0, busy=0, tag=0. Outputs therefore read 0/0/0 for every index.
- Reads: purely combinational from current state, zero latency. Same-cycle updates are not visible until the next cycle, except as described under Optional Feature.
- x0: reads always val=0, busy=0, tag=0. Allocation and commit to x0 are ignored.
- rdy_in low: no state changes; reads remain valid.
- Clock edge update, with rdy_in high and no reset:
  - Commit (cmt_valid, cmt_rd_idx!=0): val[cmt_rd_idx] <= cmt_val, always, regardless of busy or tag.
  - Commit clears busy only if busy[cmt_rd_idx]=1 and tag[cmt_rd_idx]==cmt_tag, and no allocation hits the same index this cycle.
  - Allocation (dec_rd_valid, dec_rd_idx!=0, flush=0): busy[dec_rd_idx] <= 1, tag[dec_rd_idx] <= dec_rd_tag.
  - Same index allocated and committed in one cycle: value written; busy stays 1; tag = dec_rd_tag (allocation wins).
  - Commit with tag mismatch (register renamed again later): value written; busy and tag unchanged.
  - flush: all busy <= 0 in one cycle; tags retain their values (don't-care). Same-cycle commit still writes val. Same-cycle allocation is dropped.
- Reading a register that is allocated in the same cycle returns the pre-allocation mapping. This is correct because the source read precedes destination rename, e.g. add x1,x1,x2.
- No arithmetic; widths exact, no truncation.

Optional Feature:
- Macro REGFILE_COMMIT_BYPASS_EN.
- Defined: a read of index X returns rsN_val=cmt_val, rsN_busy=0 in the same cycle when all of the following hold:
  - cmt_valid=1 and cmt_rd_idx==X, X!=0;
  - busy[X]=1 and tag[X]==cmt_tag.
- Defined, tag mismatch: no bypass; the read returns the stored busy/tag.
- Not defined: reads reflect stored state only. The consumer sees busy=1 with the tag and must capture the value from the CDB.

Test Plan:
- Reset → read x5: val 0, busy 0, tag 0. Assert rst_in low mid-run after allocations → all busy cleared immediately, without a clock edge.
- Allocate x5 tag 3 → next cycle rs1=x5 gives busy 1, tag 3. Commit x5 tag 3 val 0xDEADBEEF → next cycle val 0xDEADBEEF, busy 0.
- Allocate x7 tag 2, then x7 tag 9. Commit x7 tag 2 val 0x11 → val 0x11, busy 1, tag 9 remain.
- Same cycle: allocate x4 tag 6 and commit x4 old tag 1 val 0x22 → val 0x22, busy 1, tag 6. rs2=x4 read during that cycle shows the prior mapping.
- Allocate x3, x8, x9. Flush with simultaneous commit x8 val 0x55 and allocation x10 tag 4 → all busy 0, x8 val 0x55, x10 not busy.
- Allocate/commit x0 val 0x99 → x0 reads 0, busy 0. With REGFILE_COMMIT_BYPASS_EN: x5 busy tag 3, commit x5 tag 3 val 0x77 → same-cycle read shows 0x77, busy 0. Without the macro: busy 1, tag 3.
